fpu_rr_scheduler: RTL and testbench

//   Shares one combinational single-precision FPU (add/sub/mul/div, OpSel 00/01/10/11) among
//   NUM_REQ requesters. Round-robin arbitration, operand capture, per-op latency wait, result return.

---
 rtl/fpu_sched_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/fpu_rr_scheduler.sv | 128 ++++++++++++
 tb/tb_fpu_rr_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared constants for the FPU round-robin scheduler: op codes, FSM state
// encoding and the op-to-latency mapping.
package fpu_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Number of EXEC cycles to wait before the FPU result is sampled.
    function automatic int lat_of(input logic [1:0] op, input int lat_addsub,
                                  input int lat_mul, input int lat_div);
        case (op)
            OP_ADD, OP_SUB: return lat_addsub;
            OP_MUL:         return lat_mul;
            default:        return lat_div;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + 32'(k)) % 32'(NUM_REQ);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Shares one combinational FPU among NUM_REQ requesters: round-robin grant,
// operand capture, per-op latency wait, then a held response.
module fpu_rr_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LAT_ADDSUB = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_DIV    = 6,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [2*NUM_REQ-1:0]   req_op,
    output logic [31:0]            fpu_a,
    output logic [31:0]            fpu_b,
    output logic [1:0]             fpu_opsel,
    input  logic [31:0]            fpu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_data,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int LAT_MAX_AM = (LAT_ADDSUB > LAT_MUL) ? LAT_ADDSUB : LAT_MUL;
    localparam int LAT_MAX    = (LAT_MAX_AM > LAT_DIV) ? LAT_MAX_AM : LAT_DIV;
    localparam int CNT_W      = (LAT_MAX > 1) ? $clog2(LAT_MAX + 1) : 1;

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_reg;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic [1:0]         op_reg;
    logic [31:0]        data_reg;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [1:0]         sel_op;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[2*i +: 2];
            end
        end
    end

    // Requester handshake: a transfer happens in any cycle where
    // req_valid[i] & req_ready[i]; ready is only offered from IDLE, at most one
    // bit at a time. Response handshake: rsp_valid & rsp_ready, with rsp_id and
    // rsp_data held stable while rsp_valid waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            id_reg   <= '0;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            data_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_grant) begin
                        a_reg  <= sel_a;
                        b_reg  <= sel_b;
                        op_reg <= sel_op;
                        id_reg <= grant_idx;
                        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        cnt    <= CNT_W'(lat_of(sel_op, LAT_ADDSUB, LAT_MUL, LAT_DIV) - 1);
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        data_reg <= fpu_result;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gating with rst_n keeps every output at zero while reset is held.
    assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
    assign fpu_a     = a_reg;
    assign fpu_b     = b_reg;
    assign fpu_opsel = op_reg;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_id    = id_reg;
    assign rsp_data  = data_reg;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Bench for fpu_rr_scheduler: behavioural FPU, transaction-level reference
// model with expected-response queues, directed scenarios plus random traffic.
module tb_fpu_rr_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int LAT_ADDSUB = 1;
    localparam int LAT_MUL    = 2;
    localparam int LAT_DIV    = 6;
    localparam int ID_W       = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [31:0]           fpu_a;
    logic [31:0]           fpu_b;
    logic [1:0]            fpu_opsel;
    logic [31:0]           fpu_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  busy;
    logic [1:0]            dbg_state;

    fpu_rr_scheduler #(
        .NUM_REQ(NUM_REQ), .LAT_ADDSUB(LAT_ADDSUB), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opsel(fpu_opsel), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural FPU ----------------
    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        m = m * (2.0 ** e);
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        logic [63:0] d;
        int          e;
        d = $realtobits(x);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        real x, y;
        x = f2r(a);
        y = f2r(b);
        case (op)
            2'b00:   return r2f(x + y);
            2'b01:   return r2f(x - y);
            2'b10:   return r2f(x * y);
            default: return (y == 0.0) ? 32'h7fc00000 : r2f(x / y);
        endcase
    endfunction

    function automatic int lat_ref(input logic [1:0] op);
        case (op)
            2'b10:   return LAT_MUL;
            2'b11:   return LAT_DIV;
            default: return LAT_ADDSUB;
        endcase
    endfunction

    always_comb fpu_result = fpu_ref(fpu_a, fpu_b, fpu_opsel);

    // ---------------- checking ----------------
    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [31:0]     exp_q[$];
    logic [ID_W-1:0] id_q[$];
    logic            inflight;
    int              model_ptr;
    int unsigned     hs_cyc;
    int              cur_lat;
    logic [31:0]     cur_a, cur_b;
    logic [1:0]      cur_op;
    int              g;

    initial begin
        inflight  = 1'b0;
        model_ptr = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            inflight  = 1'b0;
            model_ptr = 0;
            exp_q.delete();
            id_q.delete();
        end else begin
            check("busy", busy, inflight);
            if (inflight) begin
                check("ready_while_busy", req_ready, '0);
                check("rsp_valid_timing", rsp_valid, cyc >= hs_cyc + cur_lat + 1);
                if (cyc > hs_cyc) begin
                    check("fpu_a_hold", fpu_a, cur_a);
                    check("fpu_b_hold", fpu_b, cur_b);
                    check("fpu_opsel_hold", fpu_opsel, cur_op);
                end
                if (cyc >= hs_cyc + cur_lat + 1 && exp_q.size() > 0) begin
                    check("rsp_id", rsp_id, id_q[0]);
                    check("rsp_data", rsp_data, exp_q[0]);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        void'(id_q.pop_front());
                        inflight = 1'b0;
                    end
                end
            end else begin
                check("rsp_valid_idle", rsp_valid, 1'b0);
                g = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && req_valid[(model_ptr + k) % NUM_REQ]) g = (model_ptr + k) % NUM_REQ;
                end
                check("req_ready_grant", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
                if (g >= 0) begin
                    inflight  = 1'b1;
                    hs_cyc    = cyc;
                    cur_a     = req_a[32*g +: 32];
                    cur_b     = req_b[32*g +: 32];
                    cur_op    = req_op[2*g +: 2];
                    cur_lat   = lat_ref(cur_op);
                    model_ptr = (g + 1) % NUM_REQ;
                    exp_q.push_back(fpu_ref(cur_a, cur_b, cur_op));
                    id_q.push_back(ID_W'(g));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [NUM_REQ-1:0] s_hs, s_rdy;
    logic               s_rv;
    logic [31:0]        s_data, s_fa;
    logic [ID_W-1:0]    s_id;

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        req_valid[i]       = 1'b1;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_op[2*i +: 2]   = op;
    endtask

    task automatic load_rand(input int i, input logic force_op, input logic [1:0] op);
        logic [1:0] o;
        int va, vb;
        o  = force_op ? op : 2'($urandom_range(0, 3));
        va = int'($urandom_range(0, 40)) - 20;
        vb = int'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) vb = -vb;
        set_req(i, r2f(real'(va)), r2f(real'(vb)), o);
    endtask

    // One clock: sample at the falling edge, retire granted requests after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_hs   = req_valid & req_ready;
        s_rdy  = req_ready;
        s_rv   = rsp_valid;
        s_data = rsp_data;
        s_id   = rsp_id;
        s_fa   = fpu_a;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~s_hs;
    endtask

    task automatic tick_until_hs(input string tag);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_hs != '0) return;
        end
        check(tag, 32'hffffffff, 0);
    endtask

    task automatic run_until_idle(input string tag);
        rsp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (!inflight && !busy) return;
            tick();
        end
        check(tag, inflight, 1'b0);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int oh2idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    int gid[5];
    int gcyc[5];
    int ng;
    int k;
    int late_hs;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fpu_a", fpu_a, 32'd0);
        check("rst_fpu_b", fpu_b, 32'd0);
        check("rst_fpu_opsel", fpu_opsel, 2'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", rsp_id, '0);
        rst_n = 1'b1;

        // 1: single multiply, latency and result
        rsp_ready = 1'b1;
        set_req(0, 32'h3F800000, 32'h40000000, 2'b10);
        tick();
        check("t1_grant", s_hs, 4'b0001);
        k = 0;
        for (int c = 1; c <= 10 && k == 0; c++) begin
            tick();
            if (s_rv) k = c;
        end
        check("t1_rsp_latency", k, 3);
        check("t1_rsp_data", s_data, 32'h40000000);
        check("t1_rsp_id", s_id, 0);
        run_until_idle("t1_idle");

        // 2: all four requesting adds from reset
        reset_dut();
        for (int i = 0; i < NUM_REQ; i++) load_rand(i, 1'b1, 2'b00);
        rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            tick();
            if (s_hs != '0) begin
                gid[ng]  = oh2idx(s_hs);
                gcyc[ng] = c;
                ng++;
                load_rand(oh2idx(s_hs), 1'b1, 2'b00);
            end
        end
        req_valid = '0;
        check("t2_grant_count", ng, 5);
        for (int i = 0; i < 5 && i < ng; i++) check("t2_grant_order", gid[i], i % NUM_REQ);
        for (int i = 1; i < 5 && i < ng; i++) check("t2_issue_interval", gcyc[i] - gcyc[i-1], 3);
        run_until_idle("t2_idle");

        // 3: divide under backpressure with other requesters waiting
        rsp_ready = 1'b0;
        set_req(2, 32'h40800000, 32'h40000000, 2'b11);
        tick_until_hs("t3_hs_timeout");
        check("t3_grant", s_hs, 4'b0100);
        load_rand(0, 1'b0, 2'b00);
        load_rand(3, 1'b0, 2'b00);
        k = 0;
        for (int c = 0; c < 12 && !s_rv; c++) tick();
        check("t3_rsp_seen", s_rv, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("t3_hold_valid", s_rv, 1'b1);
            check("t3_hold_data", s_data, 32'h40000000);
            check("t3_hold_id", s_id, 2);
            check("t3_no_ready", s_rdy, '0);
            tick();
        end
        rsp_ready = 1'b1;
        tick_until_hs("t3_next_timeout");
        check("t3_next_grant", s_hs, 4'b1000);
        req_valid = '0;
        run_until_idle("t3_idle");

        // 4: pointer wrap
        load_rand(2, 1'b0, 2'b00);
        tick_until_hs("t4a_timeout");
        check("t4_setup_grant", s_hs, 4'b0100);
        run_until_idle("t4a_idle");
        load_rand(1, 1'b0, 2'b00);
        tick_until_hs("t4b_timeout");
        check("t4_wrap_grant", s_hs, 4'b0010);
        run_until_idle("t4b_idle");
        for (int i = 0; i < 3; i++) load_rand(i, 1'b0, 2'b00);
        tick_until_hs("t4c_timeout");
        check("t4_ptr_after_wrap", s_hs, 4'b0100);
        req_valid = '0;
        run_until_idle("t4c_idle");

        // 6: captured operands stay put; dropped request never granted
        set_req(1, r2f(7.0), r2f(2.0), 2'b00);
        set_req(3, 32'h40400000, r2f(5.0), 2'b10);
        tick_until_hs("t6_timeout");
        check("t6_grant", s_hs, 4'b1000);
        req_valid[1] = 1'b0;
        req_a[32*3 +: 32] = 32'hDEADBEEF;
        for (int c = 0; c < LAT_MUL; c++) begin
            tick();
            check("t6_fpu_a_captured", s_fa, 32'h40400000);
        end
        run_until_idle("t6_idle");
        late_hs = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (s_hs != '0) late_hs++;
        end
        check("t6_no_late_grant", late_hs, 0);

        // 5: reset in the middle of a divide
        set_req(2, r2f(9.0), r2f(3.0), 2'b11);
        tick_until_hs("t5_timeout");
        check("t5_grant_div", s_hs, 4'b0100);
        tick();
        tick();
        load_rand(1, 1'b0, 2'b00);
        load_rand(3, 1'b0, 2'b00);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_rsp_valid", rsp_valid, 1'b0);
        check("t5_rst_fpu_a", fpu_a, 32'd0);
        check("t5_rst_fpu_opsel", fpu_opsel, 2'd0);
        check("t5_rst_rsp_data", rsp_data, 32'd0);
        check("t5_rst_req_ready", req_ready, '0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("t5_restart_ptr0", s_hs, 4'b0010);
        req_valid = '0;
        run_until_idle("t5_idle");

        // random traffic with drops and backpressure
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) load_rand(i, 1'b0, 2'b00);
                else if (req_valid[i] && $urandom_range(0, 24) == 0) req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        run_until_idle("rand_idle");
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
